// File: rtl/grant_lock_decoder_if.sv
// grant_lock_decoder_if: arbiter grant, input flit handshake and crossbar select bundle
interface grant_lock_decoder_if #(
  parameter int IN_N = 5
);
  localparam int W = IN_N > 1 ? $clog2(IN_N) : 1;
  logic [W-1:0]    grant_i;
  logic            grant_vld_i;
  logic [IN_N-1:0] vld_i;
  logic [IN_N-1:0] tail_i;
  logic            out_rdy_i;
  logic [IN_N-1:0] sel_oh_o;
  logic [W-1:0]    owner_o;
  logic            locked_o;
  logic            vld_o;
  logic [IN_N-1:0] rdy_o;
  logic            timeout_o;
  modport master (
    output grant_i, grant_vld_i, vld_i, tail_i, out_rdy_i,
    input  sel_oh_o, owner_o, locked_o, vld_o, rdy_o, timeout_o
  );
  modport slave (
    input  grant_i, grant_vld_i, vld_i, tail_i, out_rdy_i,
    output sel_oh_o, owner_o, locked_o, vld_o, rdy_o, timeout_o
  );
endinterface

// File: rtl/grant_lock_decoder.sv
// grant_lock_decoder: holds a crossbar output for the granted input until its tail flit.
// Optional lock watchdog compiled in with GRANT_LOCK_TIMEOUT_EN.
module grant_lock_decoder #(
  parameter int IN_N        = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  grant_lock_decoder_if.slave  bus
);
  localparam int W = IN_N > 1 ? $clog2(IN_N) : 1;
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e          state_q, state_d;
  logic [W-1:0]    owner_q, owner_d;
  logic [IN_N-1:0] sel_oh_q, sel_oh_d;
  logic            xfer;
  logic            tail_xfer;
  logic            grant_ok;
  logic            wd_fire;
  // sel_oh_q is zero when idle, so masking with it also qualifies on the lock
  assign xfer      = |(bus.vld_i & sel_oh_q) & bus.out_rdy_i;
  assign tail_xfer = xfer & |(bus.tail_i & sel_oh_q);
  assign grant_ok  = bus.grant_vld_i && int'(bus.grant_i) < IN_N;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (state_q == IDLE) begin
      if (grant_ok) begin
        state_d = LOCKED;
        owner_d = bus.grant_i;
      end
    end else if (tail_xfer || wd_fire) begin
      state_d = IDLE;
      owner_d = '0;
    end
    sel_oh_d = state_d == LOCKED ? IN_N'(1) << owner_d : '0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      sel_oh_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      sel_oh_q <= sel_oh_d;
    end
  end
`ifdef GRANT_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          timeout_q, timeout_d;
  assign wd_fire = state_q == LOCKED && !xfer && wd_cnt_q == CW'(TIMEOUT_CYC - 1);
  always_comb begin
    wd_cnt_d  = (state_q == LOCKED && !xfer && !wd_fire) ? wd_cnt_q + 1'b1 : '0;
    timeout_d = wd_fire;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout_o = timeout_q;
`else
  assign wd_fire       = 1'b0;
  assign bus.timeout_o = 1'b0;
`endif
  assign bus.sel_oh_o = sel_oh_q;
  assign bus.owner_o  = owner_q;
  assign bus.locked_o = state_q == LOCKED;
  assign bus.vld_o    = |(bus.vld_i & sel_oh_q);
  assign bus.rdy_o    = sel_oh_q & {IN_N{bus.out_rdy_i}};
endmodule

// File: tb/tb_grant_lock_decoder.sv
// tb_grant_lock_decoder: directed checks of lock, release, invalid grant, reset and watchdog
module tb_grant_lock_decoder;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  grant_lock_decoder_if #(.IN_N(5)) bus ();
  grant_lock_decoder #(.IN_N(5), .TIMEOUT_CYC(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_state(input string tag, input logic lk, input logic [4:0] sel, input logic [2:0] own);
    chk({tag, ".locked"}, 32'(bus.locked_o), 32'(lk));
    chk({tag, ".sel"}, 32'(bus.sel_oh_o), 32'(sel));
    chk({tag, ".owner"}, 32'(bus.owner_o), 32'(own));
  endtask
  initial begin
    rst_n = 1'b0;
    bus.grant_i = '0;
    bus.grant_vld_i = 1'b0;
    bus.vld_i = 5'b11111;
    bus.tail_i = '0;
    bus.out_rdy_i = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    chk_state("reset", 1'b0, 5'b00000, 3'd0);
    chk("reset.vld_o", 32'(bus.vld_o), 32'd0);
    chk("reset.rdy_o", 32'(bus.rdy_o), 32'd0);
    chk("reset.timeout", 32'(bus.timeout_o), 32'd0);
    // basic lock to input 3
    bus.vld_i = '0;
    bus.out_rdy_i = 1'b0;
    bus.grant_i = 3'd3;
    bus.grant_vld_i = 1'b1;
    tick();
    chk_state("lock3", 1'b1, 5'b01000, 3'd3);
    chk("lock3.rdy_o", 32'(bus.rdy_o), 32'd0);
    // grant while locked is ignored; other inputs' valids do not leak
    bus.grant_i = 3'd1;
    bus.vld_i = 5'b10111;
    bus.out_rdy_i = 1'b1;
    tick();
    chk_state("lock3_hold", 1'b1, 5'b01000, 3'd3);
    chk("lock3_hold.vld_o", 32'(bus.vld_o), 32'd0);
    chk("lock3_hold.rdy_o", 32'(bus.rdy_o), 32'b01000);
    // head, body, tail with a grant for input 1 presented in the tail cycle
    bus.grant_vld_i = 1'b0;
    bus.vld_i = 5'b01000;
    #1;
    chk("head.vld_o", 32'(bus.vld_o), 32'd1);
    chk("head.rdy_o", 32'(bus.rdy_o), 32'b01000);
    tick();
    chk_state("body", 1'b1, 5'b01000, 3'd3);
    chk("body.rdy_o", 32'(bus.rdy_o), 32'b01000);
    tick();
    bus.tail_i = 5'b01000;
    bus.grant_i = 3'd1;
    bus.grant_vld_i = 1'b1;
    #1;
    chk("tail.rdy_o", 32'(bus.rdy_o), 32'b01000);
    chk("tail.locked", 32'(bus.locked_o), 32'd1);
    tick();
    bus.vld_i = '0;
    bus.tail_i = '0;
    #1;
    chk_state("released", 1'b0, 5'b00000, 3'd0);
    chk("released.rdy_o", 32'(bus.rdy_o), 32'd0);
    tick();
    chk_state("regrant1", 1'b1, 5'b00010, 3'd1);
    // single-flit packet from input 1
    bus.grant_vld_i = 1'b0;
    bus.vld_i = 5'b00010;
    bus.tail_i = 5'b00010;
    tick();
    chk_state("single_flit", 1'b0, 5'b00000, 3'd0);
    // out-of-range grants
    bus.vld_i = '0;
    bus.tail_i = '0;
    bus.grant_i = 3'd6;
    bus.grant_vld_i = 1'b1;
    tick();
    chk_state("bad_grant6", 1'b0, 5'b00000, 3'd0);
    bus.grant_i = 3'd7;
    tick();
    chk_state("bad_grant7", 1'b0, 5'b00000, 3'd0);
    // reset while locked to input 2
    bus.grant_i = 3'd2;
    tick();
    chk_state("lock2", 1'b1, 5'b00100, 3'd2);
    bus.grant_vld_i = 1'b0;
    bus.vld_i = 5'b00100;
    bus.out_rdy_i = 1'b1;
    tick();
    chk_state("lock2_body", 1'b1, 5'b00100, 3'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_state("midreset", 1'b0, 5'b00000, 3'd0);
    chk("midreset.vld_o", 32'(bus.vld_o), 32'd0);
    chk("midreset.rdy_o", 32'(bus.rdy_o), 32'd0);
    // stalled lock on input 4
    bus.grant_i = 3'd4;
    bus.grant_vld_i = 1'b1;
    bus.vld_i = 5'b10000;
    bus.out_rdy_i = 1'b0;
    tick();
    bus.grant_vld_i = 1'b0;
    chk_state("lock4", 1'b1, 5'b10000, 3'd4);
`ifdef GRANT_LOCK_TIMEOUT_EN
    repeat (5) tick();
    bus.out_rdy_i = 1'b1;
    tick();
    bus.out_rdy_i = 1'b0;
    repeat (7) tick();
    chk_state("wd_pre", 1'b1, 5'b10000, 3'd4);
    chk("wd_pre.timeout", 32'(bus.timeout_o), 32'd0);
    tick();
    chk_state("wd_fire", 1'b0, 5'b00000, 3'd0);
    chk("wd_fire.timeout", 32'(bus.timeout_o), 32'd1);
    tick();
    chk("wd_after.timeout", 32'(bus.timeout_o), 32'd0);
    chk("wd_after.locked", 32'(bus.locked_o), 32'd0);
`else
    repeat (100) tick();
    chk_state("stall100", 1'b1, 5'b10000, 3'd4);
    chk("stall100.timeout", 32'(bus.timeout_o), 32'd0);
    bus.tail_i = 5'b10000;
    bus.out_rdy_i = 1'b1;
    tick();
    chk_state("stall100_tail", 1'b0, 5'b00000, 3'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/grant_lock_decoder.md
GRANT_LOCK_DECODER -- requirements
Module: grant_lock_decoder

Interface
REQ-001 Parameter IN_N, default 5: number of input ports; binary grant width is $clog2(IN_N).
REQ-002 Parameter TIMEOUT_CYC, default 64: watchdog limit in cycles; used only when GRANT_LOCK_TIMEOUT_EN is defined.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  synchronous, active-low reset.
REQ-005 grant_i  input  $clog2(IN_N)  binary index of the winning input, from the static priority arbiter.
REQ-006 grant_vld_i  input  1  grant_i is valid this cycle.
REQ-007 vld_i  input  IN_N  per-input flit valid.
REQ-008 tail_i  input  IN_N  per-input tail-flit marker, qualified by vld_i.
REQ-009 out_rdy_i  input  1  downstream output channel ready.
REQ-010 sel_oh_o  output  IN_N  one-hot crossbar select; all zero when unlocked.
REQ-011 owner_o  output  $clog2(IN_N)  binary index of the locked owner; 0 when unlocked.
REQ-012 locked_o  output  1  connection held.
REQ-013 vld_o  output  1  equals vld_i[owner] AND locked_o.
REQ-014 rdy_o  output  IN_N  equals sel_oh_o AND out_rdy_i replicated, giving back-pressure to the owner only.
REQ-015 timeout_o  output  1  one-cycle pulse on watchdog release; tied 0 when the macro is undefined.

Function
REQ-016 The FSM SHALL have two states: IDLE and LOCKED.
REQ-017 In IDLE, grant_vld_i=1 with grant_i<IN_N SHALL latch owner=grant_i and enter LOCKED on the next edge.
REQ-018 In IDLE, grant_vld_i=1 with grant_i>=IN_N SHALL be ignored, and the FSM SHALL remain in IDLE.
REQ-019 In LOCKED, grant_vld_i SHALL be ignored, and the owner SHALL NOT change.
REQ-020 A transfer SHALL be the condition locked_o AND vld_i[owner] AND out_rdy_i.
REQ-021 A transfer with tail_i[owner]=1 SHALL return the FSM to IDLE on the next edge.
REQ-022 A grant presented in the same cycle as a tail transfer SHALL be ignored; the next lock starts at least one cycle after release (one-cycle bubble).
REQ-023 Grant-to-select latency SHALL be 1 cycle: sel_oh_o is registered and asserted the cycle after the accepted grant.
REQ-024 vld_o and rdy_o SHALL be combinational from registered owner state and the live inputs.
REQ-025 A single-flit packet (head is tail) SHALL lock for exactly one transfer cycle, then release.
REQ-026 Stall with out_rdy_i=0 or vld_i[owner]=0 SHALL hold LOCKED indefinitely, except for the watchdog in REQ-031.
REQ-027 sel_oh_o SHALL always be one-hot or all zero.

Reset
REQ-028 rst_ni=0 at a clock edge SHALL force IDLE, owner=0, sel_oh_o=0, locked_o=0 and timeout_o=0, and SHALL clear the watchdog counter.
REQ-029 Reset mid-packet SHALL drop the lock with no tail required; vld_o and rdy_o SHALL be 0 from the first cycle after reset.

Configuration
REQ-030 Macro GRANT_LOCK_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-031 With the macro defined:
- A counter SHALL increment each LOCKED cycle without a transfer.
- The counter SHALL clear on any transfer and in IDLE.
- On reaching TIMEOUT_CYC-1 with no transfer that cycle, the FSM SHALL return to IDLE and pulse timeout_o for one cycle.
REQ-032 Without the macro:
- No counter logic SHALL be present.
- timeout_o SHALL be constant 0.
- The lock SHALL be released only by a tail transfer or by reset.

Verification
REQ-033 Basic lock: IN_N=5, grant_i=3 with grant_vld_i=1 in IDLE -> next cycle sel_oh_o=5'b01000, owner_o=3, locked_o=1.
REQ-034 Multi-flit packet: owner 3 sends head, body and tail flits with out_rdy_i=1 -> three transfers, rdy_o=5'b01000 throughout, locked_o=0 the cycle after the tail.
REQ-035 Grant at release: grant_i=1 presented during the tail-transfer cycle of owner 3 -> ignored; grant_i=1 re-presented one cycle later -> sel_oh_o=5'b00010.
REQ-036 Invalid grant: grant_i=6 with grant_vld_i=1 -> FSM stays in IDLE, sel_oh_o=0.
REQ-037 Reset mid-packet: rst_ni=0 for one edge while locked to owner 2 -> locked_o=0, sel_oh_o=0, owner_o=0, vld_o=0.
REQ-038 Watchdog: with GRANT_LOCK_TIMEOUT_EN and TIMEOUT_CYC=8, lock and hold out_rdy_i=0 -> release with a one-cycle timeout_o pulse after the 8th stalled cycle; without the macro -> still locked after 100 stalled cycles.
